// File: rtl/demux_2_pkg.sv
// demux_2_pkg: shared constants and types for the 2-way demux router.
//   WORD_SIZE_DEFAULT : default data word width
//   COUNT_W           : width of the optional per-output transfer counters
//   buf_state_e       : occupancy state of one 2-entry output buffer
package demux_2_pkg;

  localparam int unsigned WORD_SIZE_DEFAULT = 32;
  localparam int unsigned COUNT_W           = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/demux_2_buf.sv
// demux_2_buf: 2-entry valid/ready FIFO used as one output of the demux router.
// Optional feature macro: DEMUX_2_COUNT_EN (adds count_o transfer counter).
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   push_i       : write push_data_i this cycle (caller guarantees space or a pop)
//   push_data_i  : word to write
//   pop_ready_i  : sink accepts the head word
//   valid_o      : head word valid
//   data_o       : head word (0 after reset)
//   full_o       : both entries occupied
//   count_o      : completed output transfers, wraps at 2**COUNT_W (macro only)
module demux_2_buf
  import demux_2_pkg::*;
#(
  parameter int unsigned WORD_SIZE = WORD_SIZE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_i,
  input  logic [WORD_SIZE-1:0] push_data_i,
  input  logic                 pop_ready_i,
  output logic                 valid_o,
  output logic [WORD_SIZE-1:0] data_o,
`ifdef DEMUX_2_COUNT_EN
  output logic [COUNT_W-1:0]   count_o,
`endif
  output logic                 full_o
);

  buf_state_e           state_q, state_d;
  logic [WORD_SIZE-1:0] head_q, head_d;
  logic [WORD_SIZE-1:0] tail_q, tail_d;
  logic                 valid_q, valid_d;
  logic                 pop;

  assign pop = valid_q && pop_ready_i;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      EMPTY: begin
        if (push_i) begin
          head_d  = push_data_i;
          state_d = HALF;
        end
      end
      HALF: begin
        case ({push_i, pop})
          2'b10: begin
            tail_d  = push_data_i;
            state_d = FULL;
          end
          2'b01: state_d = EMPTY;
          // Single entry replaced in place: old head leaves, new word becomes head.
          2'b11: head_d = push_data_i;
          default: ;
        endcase
      end
      FULL: begin
        if (pop) begin
          head_d = tail_q;
          if (push_i) begin
            tail_d = push_data_i;
          end else begin
            state_d = HALF;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
    valid_d = (state_d != EMPTY);
  end

`ifdef DEMUX_2_COUNT_EN
  logic [COUNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (pop) begin
      count_d = count_q + COUNT_W'(1);
    end
  end

  assign count_o = count_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= 1'b0;
`ifdef DEMUX_2_COUNT_EN
      count_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
`ifdef DEMUX_2_COUNT_EN
      count_q <= count_d;
`endif
    end
  end

  assign valid_o = valid_q;
  assign data_o  = head_q;
  assign full_o  = (state_q == FULL);

endmodule

// File: rtl/demux_2_router.sv
// demux_2_router: routes a valid/ready input stream to one of two buffered outputs.
// Optional feature macro: DEMUX_2_COUNT_EN (adds out0_count/out1_count ports).
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid/in_ready        : input handshake
//   in_data, in_sel          : input word and destination (0 -> out0, 1 -> out1)
//   outN_valid/outN_ready    : output handshakes, N = 0, 1
//   outN_data                : output buffer head words
//   outN_count               : per-output transfer counters (macro only)
module demux_2_router
  import demux_2_pkg::*;
#(
  parameter int unsigned WORD_SIZE = WORD_SIZE_DEFAULT,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] in_data,
  input  logic                 in_sel,
  output logic                 out0_valid,
  input  logic                 out0_ready,
  output logic [WORD_SIZE-1:0] out0_data,
  output logic                 out1_valid,
  input  logic                 out1_ready,
`ifdef DEMUX_2_COUNT_EN
  output logic [COUNT_W-1:0]   out0_count,
  output logic [COUNT_W-1:0]   out1_count,
`endif
  output logic [WORD_SIZE-1:0] out1_data
);

  if (BUF_DEPTH != 2) begin : g_bad_depth
    $error("demux_2_router: only BUF_DEPTH == 2 is supported");
  end

  logic full0, full1;
  logic push0, push1;

  // A FULL buffer can still accept when its sink drains the head in the same cycle.
  // Only the selected buffer matters, so a stalled out0 also blocks traffic for out1.
  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      if (in_sel) begin
        in_ready = !full1 || out1_ready;
      end else begin
        in_ready = !full0 || out0_ready;
      end
    end
  end

  assign push0 = in_valid && in_ready && !in_sel;
  assign push1 = in_valid && in_ready && in_sel;

  demux_2_buf #(
    .WORD_SIZE (WORD_SIZE)
  ) u_buf0 (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push0),
    .push_data_i (in_data),
    .pop_ready_i (out0_ready),
    .valid_o     (out0_valid),
    .data_o      (out0_data),
`ifdef DEMUX_2_COUNT_EN
    .count_o     (out0_count),
`endif
    .full_o      (full0)
  );

  demux_2_buf #(
    .WORD_SIZE (WORD_SIZE)
  ) u_buf1 (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push1),
    .push_data_i (in_data),
    .pop_ready_i (out1_ready),
    .valid_o     (out1_valid),
    .data_o      (out1_data),
`ifdef DEMUX_2_COUNT_EN
    .count_o     (out1_count),
`endif
    .full_o      (full1)
  );

endmodule

// File: tb/tb_demux_2_router.sv
// tb_demux_2_router: self-checking bench for demux_2_router using queue-based reference model.
module tb_demux_2_router;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, in_sel;
  logic [W-1:0] in_data;
  logic         out0_valid, out0_ready, out1_valid, out1_ready;
  logic [W-1:0] out0_data, out1_data;
`ifdef DEMUX_2_COUNT_EN
  logic [15:0]  out0_count, out1_count;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: one queue per output plus modulo-2**16 transfer counters.
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  logic [15:0]  m_cnt0 = 16'd0;
  logic [15:0]  m_cnt1 = 16'd0;

  always #5 clk = ~clk;

  demux_2_router #(
    .WORD_SIZE (W),
    .BUF_DEPTH (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
`ifdef DEMUX_2_COUNT_EN
    .out0_count (out0_count),
    .out1_count (out1_count),
`endif
    .out1_data  (out1_data)
  );

  function automatic bit exp_ready();
    if (rst) return 1'b0;
    if (in_sel) return (q1.size() < 2) || out1_ready;
    return (q0.size() < 2) || out0_ready;
  endfunction

  // Apply one rising edge to the model, using the inputs currently driven.
  task automatic model_edge();
    bit acc;
    if (rst) begin
      q0.delete();
      q1.delete();
      m_cnt0 = 16'd0;
      m_cnt1 = 16'd0;
      return;
    end
    acc = in_valid && exp_ready();
    if (q0.size() != 0 && out0_ready) begin
      void'(q0.pop_front());
      m_cnt0 = m_cnt0 + 16'd1;
    end
    if (q1.size() != 0 && out1_ready) begin
      void'(q1.pop_front());
      m_cnt1 = m_cnt1 + 16'd1;
    end
    if (acc) begin
      if (in_sel) q1.push_back(in_data);
      else        q0.push_back(in_data);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit sel, input logic [W-1:0] d,
                       input bit r0, input bit r1);
    in_valid   = v;
    in_sel     = sel;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 1'b0, 32'h1234_5678, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (in_ready !== 1'b0) begin
        failures++;
        $display("FAIL reset_in_ready: got %b want 0", in_ready);
      end
      tick();
    end
    checks++;
    if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid: got %b%b want 00", out0_valid, out1_valid);
    end
    checks++;
    if (out0_data !== '0 || out1_data !== '0) begin
      failures++;
      $display("FAIL reset_data: got %h %h want 0 0", out0_data, out1_data);
    end
`ifdef DEMUX_2_COUNT_EN
    checks++;
    if (out0_count !== 16'd0 || out1_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_count: got %0d %0d want 0 0", out0_count, out1_count);
    end
`endif
    rst = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_routing();
    do_reset();
    drive(1'b1, 1'b0, 32'hA5A5_0001, 1'b1, 1'b1);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL route_ready0: got %b want 1", in_ready);
    end
    tick();
    drive(1'b1, 1'b1, 32'h0000_BEEF, 1'b1, 1'b1);
    checks++;
    if (out0_valid !== 1'b1 || out0_data !== 32'hA5A5_0001) begin
      failures++;
      $display("FAIL route_out0: got v=%b d=%h want v=1 d=a5a50001", out0_valid, out0_data);
    end
    tick();
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
    checks++;
    if (out1_valid !== 1'b1 || out1_data !== 32'h0000_BEEF || out0_valid !== 1'b0) begin
      failures++;
      $display("FAIL route_out1: got v1=%b d1=%h v0=%b want v1=1 d1=0000beef v0=0",
               out1_valid, out1_data, out0_valid);
    end
    tick();
`ifdef DEMUX_2_COUNT_EN
    checks++;
    if (out0_count !== 16'd1 || out1_count !== 16'd1) begin
      failures++;
      $display("FAIL route_count: got %0d %0d want 1 1", out0_count, out1_count);
    end
`endif
  endtask

  task automatic test_backpressure();
    logic [W-1:0] w[3];
    w[0] = 32'h0000_0001; w[1] = 32'h0000_0002; w[2] = 32'h0000_0003;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, w[i], 1'b0, 1'b0);
      checks++;
      if (in_ready !== (i < 2)) begin
        failures++;
        $display("FAIL bp_ready%0d: got %b want %b", i, in_ready, (i < 2));
      end
      if (i < 2) tick();
    end
    tick();
    checks++;
    if (out0_data !== w[0] || out0_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_stable: got v=%b d=%h want v=1 d=%h", out0_valid, out0_data, w[0]);
    end
    drive(1'b1, 1'b0, w[2], 1'b1, 1'b0);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_drain_ready: got %b want 1", in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out0_valid !== 1'b1 || out0_data !== w[i]) begin
        failures++;
        $display("FAIL bp_order%0d: got v=%b d=%h want v=1 d=%h", i, out0_valid, out0_data, w[i]);
      end
      tick();
      drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
    end
    checks++;
    if (out0_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_empty: got %b want 0", out0_valid);
    end
  endtask

  task automatic test_hol_block();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 32'h0000_1000 + i, 1'b0, 1'b1);
      tick();
    end
    // A sel=0 word is pending at the input; the sel=1 word waits behind it.
    drive(1'b1, 1'b0, 32'h0000_1002, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready !== 1'b0 || out1_valid !== 1'b0) begin
        failures++;
        $display("FAIL hol_block%0d: got rdy=%b v1=%b want 0 0", i, in_ready, out1_valid);
      end
      tick();
    end
    drive(1'b1, 1'b0, 32'h0000_1002, 1'b1, 1'b1);
    tick();
    drive(1'b1, 1'b1, 32'h0000_2000, 1'b1, 1'b1);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL hol_release: got %b want 1", in_ready);
    end
    tick();
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (out1_valid !== 1'b1 || out1_data !== 32'h0000_2000) begin
      failures++;
      $display("FAIL hol_out1: got v=%b d=%h want v=1 d=00002000", out1_valid, out1_data);
    end
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic test_full_push_pop();
    do_reset();
    drive(1'b1, 1'b1, 32'hC000_0001, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 32'hC000_0002, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 32'hC000_0003, 1'b0, 1'b1);
    checks++;
    if (in_ready !== 1'b1 || out1_data !== 32'hC000_0001) begin
      failures++;
      $display("FAIL fpp_ready: got rdy=%b d=%h want 1 c0000001", in_ready, out1_data);
    end
    tick();
    // Still FULL: with the sink stalled the input must stall again.
    drive(1'b1, 1'b1, 32'hC000_0004, 1'b0, 1'b0);
    checks++;
    if (in_ready !== 1'b0 || out1_data !== 32'hC000_0002) begin
      failures++;
      $display("FAIL fpp_full: got rdy=%b d=%h want 0 c0000002", in_ready, out1_data);
    end
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
    tick();
    checks++;
    if (out1_valid !== 1'b1 || out1_data !== 32'hC000_0003) begin
      failures++;
      $display("FAIL fpp_order: got v=%b d=%h want 1 c0000003", out1_valid, out1_data);
    end
    tick();
    checks++;
    if (out1_valid !== 1'b0) begin
      failures++;
      $display("FAIL fpp_empty: got %b want 0", out1_valid);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i[0], 32'hD000_0000 + i, 1'b0, 1'b0);
      tick();
    end
    rst = 1'b1;
    drive(1'b1, 1'b0, 32'hDEAD_DEAD, 1'b1, 1'b1);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL mrst_ready: got %b want 0", in_ready);
    end
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out0_valid !== 1'b0 || out1_valid !== 1'b0 || out0_data !== '0 || out1_data !== '0) begin
        failures++;
        $display("FAIL mrst_clear%0d: got v=%b%b d=%h %h want 00 0 0",
                 i, out0_valid, out1_valid, out0_data, out1_data);
      end
      tick();
    end
    drive(1'b1, 1'b0, 32'hF00D_0001, 1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
    checks++;
    if (out0_valid !== 1'b1 || out0_data !== 32'hF00D_0001) begin
      failures++;
      $display("FAIL mrst_fresh: got v=%b d=%h want 1 f00d0001", out0_valid, out0_data);
    end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst = ($urandom_range(0, 39) == 0);
      drive($urandom_range(0, 2) != 0, $urandom_range(0, 1) != 0, $urandom,
            $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0);
      checks++;
      if (in_ready !== exp_ready()) begin
        failures++;
        $display("FAIL rnd_ready@%0d: got %b want %b", cyc, in_ready, exp_ready());
      end
      checks++;
      if (out0_valid !== (q0.size() != 0) || out1_valid !== (q1.size() != 0)) begin
        failures++;
        $display("FAIL rnd_valid@%0d: got %b%b want %b%b", cyc, out0_valid, out1_valid,
                 q0.size() != 0, q1.size() != 0);
      end
      if (q0.size() != 0) begin
        checks++;
        if (out0_data !== q0[0]) begin
          failures++;
          $display("FAIL rnd_data0@%0d: got %h want %h", cyc, out0_data, q0[0]);
        end
      end
      if (q1.size() != 0) begin
        checks++;
        if (out1_data !== q1[0]) begin
          failures++;
          $display("FAIL rnd_data1@%0d: got %h want %h", cyc, out1_data, q1[0]);
        end
      end
`ifdef DEMUX_2_COUNT_EN
      checks++;
      if (out0_count !== m_cnt0 || out1_count !== m_cnt1) begin
        failures++;
        $display("FAIL rnd_count@%0d: got %0d %0d want %0d %0d", cyc, out0_count, out1_count,
                 m_cnt0, m_cnt1);
      end
`endif
      tick();
    end
    rst = 1'b0;
  endtask

`ifdef DEMUX_2_COUNT_EN
  task automatic test_count_wrap();
    do_reset();
    drive(1'b1, 1'b0, 32'h0BAD_CAFE, 1'b1, 1'b0);
    for (int i = 0; i < 70000 && m_cnt0 != 16'hFFFF; i++) tick();
    checks++;
    if (out0_count !== 16'hFFFF) begin
      failures++;
      $display("FAIL wrap_preload: got %0d want 65535", out0_count);
    end
    tick();
    checks++;
    if (out0_count !== 16'h0000) begin
      failures++;
      $display("FAIL wrap_zero: got %0d want 0", out0_count);
    end
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
    tick();
  endtask
`endif

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    test_reset();
    test_routing();
    test_backpressure();
    test_hol_block();
    test_full_push_pop();
    test_mid_reset();
    test_random();
`ifdef DEMUX_2_COUNT_EN
    test_count_wrap();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux_2_router.md
DEMUX_2_ROUTER -- requirements
Module: demux_2_router

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32, which sets the data word width in bits.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, the entries per output buffer; only the value 2 is supported.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  input word present.
REQ-006 SHALL have port in_ready  output  1  router accepts the input word this cycle.
REQ-007 SHALL have port in_data  input  WORD_SIZE  input word.
REQ-008 SHALL have port in_sel  input  1  destination: 0 routes to out0, 1 routes to out1.
REQ-009 SHALL have ports out0_valid/out1_valid  output  1  each, meaning the buffer head is valid.
REQ-010 SHALL have ports out0_ready/out1_ready  input  1  each, meaning the sink accepts the head.
REQ-011 SHALL have ports out0_data/out1_data  output  WORD_SIZE  each, the buffer head word.
REQ-012 SHALL have ports out0_count/out1_count  output  16  each, the transfer counter; present only with DEMUX_2_COUNT_EN.

Function
REQ-013 SHALL transfer an input word when in_valid && in_ready at a rising edge, and an output word when outN_valid && outN_ready.
REQ-014 SHALL write an accepted word into the buffer selected by in_sel; the word is visible on outN_data with outN_valid=1 on the next cycle (latency 1).
REQ-015 SHALL give each buffer states EMPTY (0 entries), HALF (1 entry) and FULL (2 entries), with these transitions:
- push only: +1
- pop only: -1
- push and pop together: unchanged.
REQ-016 SHALL drive in_ready = (selected buffer not FULL) || (selected buffer FULL && its outN_ready); this is combinational from in_sel and the state.
REQ-017 SHALL NOT let in_ready depend on in_valid.
REQ-018 SHALL preserve order per output, first-in first-out.
REQ-019 SHALL stall the input while the selected buffer is FULL and not draining, even when the other buffer has space (no reordering or bypass).
REQ-020 SHALL leave outN_data stable while outN_valid=1 and outN_ready=0.
REQ-021 SHALL keep outN_valid asserted until the transfer occurs.
REQ-022 SHALL, on a simultaneous push and pop to one FULL buffer, pop the old head, push the new word at the tail, and keep the count at 2.
REQ-023 SHALL, on a simultaneous push to one channel and pop from the other, perform both independently.
REQ-024 SHALL ignore in_data and in_sel when in_valid=0.
REQ-025 SHALL treat outN_data as don't-care while outN_valid=0.

Reset
REQ-026 SHALL, when rst=1 at a rising edge, empty both buffers.
REQ-027 SHALL drive the following values during and after reset:
- out0_valid=0 and out1_valid=0
- out0_data and out1_data = 0
- out0_count and out1_count = 0.
REQ-028 SHALL drive in_ready=0 while rst=1.
REQ-029 SHALL discard any words buffered when reset asserts mid-operation, with no partial transfer.
REQ-030 SHALL treat a handshake in a cycle where rst=1 as not occurring.

Configuration
REQ-031 SHALL, with macro DEMUX_2_COUNT_EN defined, include the out0_count and out1_count ports.
REQ-032 SHALL increment each counter by 1 per completed output transfer on its channel, wrapping 16'hFFFF to 16'h0000 with no flag.
REQ-033 SHALL, without DEMUX_2_COUNT_EN, omit the counter ports and logic; all other behaviour is identical.

Structure
REQ-034 SHALL place the following in shared package demux_2_pkg:
- the default WORD_SIZE constant
- COUNT_W=16
- the buffer state enumeration (EMPTY, HALF, FULL).
REQ-035 SHALL instantiate sub-module demux_2_buf twice, once per output; each is a 2-entry valid/ready FIFO holding the state, head/tail storage and optional counter.

Verification
REQ-036 SHALL cover reset: rst=1 for 2 cycles with in_valid=1 -> in_ready=0, both outN_valid=0, both counts 0.
REQ-037 SHALL cover routing: push 32'hA5A5_0001 with sel=0, then 32'h0000_BEEF with sel=1, both sinks ready -> out0 shows A5A5_0001 the next cycle and out1 shows 0000_BEEF; out0_count=1 and out1_count=1.
REQ-038 SHALL cover backpressure: out0_ready=0, push 3 words to sel=0 -> first 2 accepted and in_ready=0 on the third; after out0_ready=1 the words drain in order 1, 2, 3.
REQ-039 SHALL cover head-of-line blocking: out0 FULL and stalled, present a sel=1 word behind a pending sel=0 word -> in_ready=0 and out1_valid stays 0.
REQ-040 SHALL cover FULL push/pop: out1 FULL, out1_ready=1, push with sel=1 -> accepted, count stays FULL, order preserved.
REQ-041 SHALL cover counter wrap: preload 65535 transfers on out0, then 1 more -> out0_count=0.
REQ-042 SHALL cover mid-operation reset: rst for 1 cycle with both buffers FULL -> both valids 0 on the next cycle and no stale data is delivered afterwards.
